velocity_update_ctrl: RTL and testbench

Per-cell velocity update sequencer sitting directly downstream of a cell's velocity memory (single-port RAM, 1-cycle read latency, address 0 = particle count, data {vz, vy, vx}).
- On start, reads the cell particle count, then for each particle: reads the old velocity, waits for a per-particle velocity delta from the force/acceleration path, adds it component-wise, writes the result back in place, and forwards it to motion update over a valid/ready stream.
- One particle in flight at a time; one instance per cell.

---
 rtl/velocity_update_ctrl.sv | 159 +++++++++++++++
 tb/tb_velocity_update_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/velocity_update_ctrl.sv
// Per-cell velocity update sequencer: read count, then per particle read v, add dv, write back, stream out.
// Optional build macro VELOCITY_SATURATE_EN selects saturating (vs wrapping) component adds.
module velocity_update_ctrl #(
  parameter int COMP_WIDTH   = 32,
  parameter int DATA_WIDTH   = 3*COMP_WIDTH,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rden,
  output logic                  ram_wren,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q,
  input  logic                  dv_valid,
  output logic                  dv_ready,
  input  logic [DATA_WIDTH-1:0] dv_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vel,
  output logic [ADDR_WIDTH-1:0] out_pid
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM-1);

  typedef enum logic [3:0] {
    IDLE, RD_CNT, LAT_CNT, RD_VEL, LAT_VEL, WAIT_DV, WRITE, OUT, DONE
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   idx_q, cnt_q, cnt_d, idx_d, addr_q, pid_q;
  logic [DATA_WIDTH-1:0]   v_q, sum_q, sum_d;
  logic                    rden_q, wren_q, dv_ready_q, out_valid_q, busy_q, done_q;

  function automatic logic [COMP_WIDTH-1:0] add_comp(input logic signed [COMP_WIDTH-1:0] a,
                                                     input logic signed [COMP_WIDTH-1:0] b);
`ifdef VELOCITY_SATURATE_EN
    logic signed [COMP_WIDTH:0] s;
    s = {a[COMP_WIDTH-1], a} + {b[COMP_WIDTH-1], b};
    // Sign bits disagreeing means the true sum left the representable range.
    if (s[COMP_WIDTH] != s[COMP_WIDTH-1])
      add_comp = s[COMP_WIDTH] ? {1'b1, {(COMP_WIDTH-1){1'b0}}} : {1'b0, {(COMP_WIDTH-1){1'b1}}};
    else
      add_comp = s[COMP_WIDTH-1:0];
`else
    add_comp = a + b;
`endif
  endfunction

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < 3; c++)
      sum_d[c*COMP_WIDTH +: COMP_WIDTH] = add_comp(v_q[c*COMP_WIDTH +: COMP_WIDTH],
                                                   dv_data[c*COMP_WIDTH +: COMP_WIDTH]);
    cnt_d = ram_q[ADDR_WIDTH-1:0];
    if (cnt_d > CNT_MAX) cnt_d = CNT_MAX;
    idx_d = idx_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      pid_q       <= '0;
      v_q         <= '0;
      sum_q       <= '0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      dv_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Strobes and address default low so addr is 0 whenever no RAM access is issued.
      done_q <= 1'b0;
      rden_q <= 1'b0;
      wren_q <= 1'b0;
      addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RD_CNT;
            busy_q  <= 1'b1;
            rden_q  <= 1'b1;
          end
        end
        RD_CNT: state_q <= LAT_CNT;
        LAT_CNT: begin
          cnt_q <= cnt_d;
          idx_q <= ADDR_WIDTH'(1);
          if (cnt_d == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RD_VEL;
            rden_q  <= 1'b1;
            addr_q  <= ADDR_WIDTH'(1);
          end
        end
        RD_VEL: state_q <= LAT_VEL;
        LAT_VEL: begin
          v_q        <= ram_q;
          state_q    <= WAIT_DV;
          dv_ready_q <= 1'b1;
        end
        WAIT_DV: begin
          if (dv_valid) begin
            sum_q       <= sum_d;
            dv_ready_q  <= 1'b0;
            state_q     <= WRITE;
            wren_q      <= 1'b1;
            addr_q      <= idx_q;
            out_valid_q <= 1'b1;
            pid_q       <= idx_q;
          end
        end
        WRITE, OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == cnt_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              state_q <= RD_VEL;
              rden_q  <= 1'b1;
              addr_q  <= idx_d;
            end
          end else begin
            state_q <= OUT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_addr  = addr_q;
  assign ram_rden  = rden_q;
  assign ram_wren  = wren_q;
  assign ram_wdata = sum_q;
  assign dv_ready  = dv_ready_q;
  assign out_valid = out_valid_q;
  assign out_vel   = sum_q;
  assign out_pid   = pid_q;

endmodule

// File: tb/tb_velocity_update_ctrl.sv
// Directed bench for velocity_update_ctrl with a behavioural 1-cycle-latency velocity RAM.
module tb_velocity_update_ctrl;
  localparam int CW = 32;
  localparam int DW = 96;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, ram_rden, ram_wren;
  logic [AW-1:0] ram_addr, out_pid;
  logic [DW-1:0] ram_wdata, ram_q, dv_data, out_vel;
  logic          dv_valid, dv_ready, out_valid, out_ready;

  logic [DW-1:0] mem [0:255];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  int wr_cnt [0:255];
  int rd_total = 0, wr_total = 0, viol = 0, cyc = 0;
  int total_cnt = 0, bad_cnt = 0;

  velocity_update_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_wren(ram_wren),
    .ram_wdata(ram_wdata), .ram_q(ram_q), .dv_valid(dv_valid), .dv_ready(dv_ready),
    .dv_data(dv_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_vel(out_vel), .out_pid(out_pid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    if (ram_rden) ram_q <= mem[ram_addr];
    if (ram_wren) begin
      wr_cnt[ram_addr] <= wr_cnt[ram_addr] + 1;
      wr_total <= wr_total + 1;
    end
    if (ram_rden) rd_total <= rd_total + 1;
    if (!rst && ((ram_rden && ram_wren) || (ram_wren && ram_addr == '0) ||
                 (!ram_rden && !ram_wren && ram_addr != '0)))
      viol <= viol + 1;
  end

  function automatic logic [DW-1:0] pk(input logic [CW-1:0] z, input logic [CW-1:0] y,
                                       input logic [CW-1:0] x);
    return {z, y, x};
  endfunction

  task automatic load(input int a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = 8'(a); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dv_valid = 1'b0; dv_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++; if ({busy, done, ram_rden, ram_wren, dv_ready, out_valid} !== 6'b0) begin
      bad_cnt++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, ram_rden, ram_wren, dv_ready, out_valid}); end
    total_cnt++; if ({ram_addr, out_pid} !== 16'h0) begin
      bad_cnt++; $display("FAIL reset_addr got=%h exp=0000", {ram_addr, out_pid}); end
    total_cnt++; if ({ram_wdata, out_vel} !== '0) begin
      bad_cnt++; $display("FAIL reset_data got=%h exp=0", ram_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_count;
    int rd0, wr0;
    logic dvr_seen;
    load(0, '0);
    rd0 = rd_total; wr0 = wr_total; dvr_seen = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    total_cnt++; if ({ram_rden, busy, ram_addr} !== {2'b11, 8'h00}) begin
      bad_cnt++; $display("FAIL zero_rdcnt got=%b exp=1100000000", {ram_rden, busy, ram_addr}); end
    dvr_seen |= dv_ready; @(negedge clk);
    total_cnt++; if ({ram_rden, done} !== 2'b00) begin
      bad_cnt++; $display("FAIL zero_lat got=%b exp=00", {ram_rden, done}); end
    dvr_seen |= dv_ready; @(negedge clk);
    total_cnt++; if ({done, busy} !== 2'b11) begin
      bad_cnt++; $display("FAIL zero_done got=%b exp=11", {done, busy}); end
    dvr_seen |= dv_ready; @(negedge clk);
    total_cnt++; if ({done, busy} !== 2'b00) begin
      bad_cnt++; $display("FAIL zero_idle got=%b exp=00", {done, busy}); end
    total_cnt++; if (rd_total - rd0 != 1 || wr_total != wr0 || dvr_seen !== 1'b0) begin
      bad_cnt++; $display("FAIL zero_access got rd=%0d wr=%0d dvr=%b exp rd=1 wr=0 dvr=0",
                          rd_total - rd0, wr_total - wr0, dvr_seen); end
  endtask

  task automatic test_three_particles;
    int wr_cyc [4];
    int base [4];
    int pids [$];
    logic seen_done;
    load(0, 96'd3);
    for (int a = 1; a <= 3; a++) load(a, pk(3, 2, 1));
    for (int a = 0; a < 4; a++) begin base[a] = wr_cnt[a]; wr_cyc[a] = 0; end
    dv_data = pk(1, 1, 1); dv_valid = 1'b1; out_ready = 1'b1; seen_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (ram_wren && ram_addr >= 1 && ram_addr <= 3) wr_cyc[ram_addr] = cyc;
      if (out_valid && out_ready) pids.push_back(int'(out_pid));
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    dv_valid = 1'b0;
    total_cnt++; if (!seen_done) begin
      bad_cnt++; $display("FAIL three_done got=timeout exp=done"); end
    total_cnt++; if (pids.size() != 3 || pids[0] != 1 || pids[1] != 2 || pids[2] != 3) begin
      bad_cnt++; $display("FAIL three_pids got n=%0d exp 1,2,3", pids.size()); end
    for (int a = 1; a <= 3; a++) begin
      total_cnt++; if (mem[a] !== pk(4, 3, 2) || wr_cnt[a] - base[a] != 1) begin
        bad_cnt++; $display("FAIL three_mem%0d got=%h n=%0d exp=%h n=1", a, mem[a], wr_cnt[a] - base[a], pk(4, 3, 2)); end
    end
    total_cnt++; if (wr_cyc[2] - wr_cyc[1] != 4 || wr_cyc[3] - wr_cyc[2] != 4) begin
      bad_cnt++; $display("FAIL three_rate got=%0d,%0d exp=4,4", wr_cyc[2] - wr_cyc[1], wr_cyc[3] - wr_cyc[2]); end
    total_cnt++; if (wr_cnt[0] != base[0] || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL three_addr0_busy got wr0=%0d busy=%b exp=0,0", wr_cnt[0] - base[0], busy); end
  endtask

  task automatic test_back_pressure;
    int base [4];
    int stall, hs2, rd3;
    logic started, seen_done;
    load(0, 96'd3);
    for (int a = 1; a <= 3; a++) load(a, pk(3, 2, 1));
    for (int a = 0; a < 4; a++) base[a] = wr_cnt[a];
    dv_data = pk(1, 1, 1); dv_valid = 1'b1; out_ready = 1'b1;
    stall = 0; hs2 = -1; rd3 = -1; started = 1'b0; seen_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      if (out_valid && out_pid == 8'd2 && !started) begin started = 1'b1; stall = 5; end
      out_ready = (stall == 0);
      if (stall > 0) begin
        total_cnt++; if ({out_valid, out_pid} !== {1'b1, 8'd2} || out_vel !== pk(4, 3, 2)) begin
          bad_cnt++; $display("FAIL bp_hold got v=%b pid=%0d vel=%h exp v=1 pid=2 vel=%h",
                              out_valid, out_pid, out_vel, pk(4, 3, 2)); end
        stall--;
      end
      if (out_valid && out_ready && out_pid == 8'd2) hs2 = cyc;
      if (ram_rden && ram_addr == 8'd3 && rd3 < 0) rd3 = cyc;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b1; dv_valid = 1'b0;
    total_cnt++; if (!seen_done || !started) begin
      bad_cnt++; $display("FAIL bp_done got done=%b stall=%b exp=1,1", seen_done, started); end
    total_cnt++; if (rd3 != hs2 + 1 || hs2 < 0) begin
      bad_cnt++; $display("FAIL bp_rd3 got rd3=%0d hs2=%0d exp rd3=hs2+1", rd3, hs2); end
    for (int a = 1; a <= 3; a++) begin
      total_cnt++; if (wr_cnt[a] - base[a] != 1 || mem[a] !== pk(4, 3, 2)) begin
        bad_cnt++; $display("FAIL bp_wr%0d got n=%0d mem=%h exp n=1 mem=%h", a, wr_cnt[a] - base[a], mem[a], pk(4, 3, 2)); end
    end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] exp_v, got_v;
    logic seen_done;
`ifdef VELOCITY_SATURATE_EN
    exp_v = pk(32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF);
`else
    exp_v = pk(32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000);
`endif
    load(0, 96'd1);
    load(1, pk(32'd5, 32'h8000_0000, 32'h7FFF_FFFF));
    dv_data = pk(32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1); dv_valid = 1'b1; out_ready = 1'b1;
    got_v = '0; seen_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      if (out_valid && out_ready) got_v = out_vel;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    dv_valid = 1'b0;
    total_cnt++; if (got_v !== exp_v) begin
      bad_cnt++; $display("FAIL ovf_out got=%h exp=%h", got_v, exp_v); end
    total_cnt++; if (mem[1] !== exp_v || !seen_done) begin
      bad_cnt++; $display("FAIL ovf_mem got=%h done=%b exp=%h done=1", mem[1], seen_done, exp_v); end
  endtask

  task automatic test_reset_mid_pass;
    int base2, npid;
    logic found, seen_done;
    load(0, 96'd3);
    for (int a = 1; a <= 3; a++) load(a, pk(3, 2, 1));
    base2 = wr_cnt[2];
    dv_data = pk(1, 1, 1); dv_valid = 1'b1; out_ready = 1'b1; found = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && dv_valid; c++) begin
      if (ram_wren && ram_addr == 8'd1) dv_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 10 && !found; c++) begin
      if (dv_ready) found = 1'b1; else @(negedge clk);
    end
    total_cnt++; if (!found) begin
      bad_cnt++; $display("FAIL rstmid_wait got=timeout exp=dv_ready"); end
    rst = 1'b1; @(negedge clk);
    total_cnt++; if ({busy, done, ram_rden, ram_wren, dv_ready, out_valid, ram_addr, out_pid} !== 22'b0
                     || out_vel !== '0) begin
      bad_cnt++; $display("FAIL rstmid_out got=%b exp=0", {busy, done, ram_rden, ram_wren, dv_ready, out_valid}); end
    rst = 1'b0; dv_valid = 1'b1; repeat (3) @(negedge clk);
    total_cnt++; if (wr_cnt[2] != base2 || mem[2] !== pk(3, 2, 1) || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL rstmid_nowr got n=%0d mem=%h busy=%b exp n=0 mem=%h busy=0",
                          wr_cnt[2] - base2, mem[2], busy, pk(3, 2, 1)); end
    load(1, pk(3, 2, 1));
    npid = 0; seen_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (out_valid && out_ready) npid++;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    dv_valid = 1'b0;
    total_cnt++; if (!seen_done || npid != 3) begin
      bad_cnt++; $display("FAIL rstmid_rerun got done=%b n=%0d exp done=1 n=3", seen_done, npid); end
    for (int a = 1; a <= 3; a++) begin
      total_cnt++; if (mem[a] !== pk(4, 3, 2)) begin
        bad_cnt++; $display("FAIL rstmid_mem%0d got=%h exp=%h", a, mem[a], pk(4, 3, 2)); end
    end
  endtask

  task automatic test_count_clamp;
    int nhs, last, base220;
    logic seen_done;
    load(0, 96'd255);
    for (int a = 1; a <= 220; a++) load(a, pk(0, 0, 32'(a)));
    base220 = wr_cnt[220];
    dv_data = pk(1, 1, 1); dv_valid = 1'b1; out_ready = 1'b1;
    nhs = 0; last = 0; seen_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int c = 0; c < 1200 && !seen_done; c++) begin
      if (out_valid && out_ready) begin nhs++; last = int'(out_pid); end
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    dv_valid = 1'b0;
    total_cnt++; if (!seen_done || nhs != 219 || last != 219) begin
      bad_cnt++; $display("FAIL clamp_count got done=%b n=%0d last=%0d exp done=1 n=219 last=219",
                          seen_done, nhs, last); end
    total_cnt++; if (mem[219] !== pk(1, 1, 220) || mem[220] !== pk(0, 0, 220) || wr_cnt[220] != base220) begin
      bad_cnt++; $display("FAIL clamp_mem got m219=%h m220=%h exp m219=%h m220=%h",
                          mem[219], mem[220], pk(1, 1, 220), pk(0, 0, 220)); end
  endtask

  task automatic test_bus_rules;
    total_cnt++; if (viol != 0) begin
      bad_cnt++; $display("FAIL bus_rules got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset;
    test_zero_count;
    test_three_particles;
    test_back_pressure;
    test_overflow;
    test_reset_mid_pass;
    test_count_clamp;
    test_bus_rules;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
